data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the core's load/store port: accepts one request at a time via
//   valid/ready, waits a configurable number of wait states, then returns read data or a
//   write acknowledge via a held response. Handles byte/half/word lanes, sign/zero extension,
//   misalignment and out-of-range errors. Replaces the always-ready word memory on the data path.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//   WAIT_STATES  2     cycles spent in WAIT before the access completes (0..15)
// PORTS
//   clk           in   1   clock, all state updates on rising edge
//   reset         in   1   asynchronous, active-high reset
//   req_valid     in   1   request present
//   req_ready     out  1   responder can accept a request this cycle
//   req_write     in   1   1 = store, 0 = load
//   req_addr      in   32  byte address
//   req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1   loads: 1 = zero-extend, 0 = sign-extend (ignored for word/stores)
//   req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   rsp_valid     out  1   response present
//   rsp_ready     in   1   requester accepts response
//   rsp_rdata     out  32  load result, extended; 0 for stores and errors
//   rsp_error     out  1   misaligned, out-of-range or illegal size
// BEHAVIOUR
//   Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0.
//     Storage array is not cleared by reset; a pending store is dropped.
//   FSM states IDLE -> WAIT -> RESP -> IDLE:
//     IDLE: req_ready=1. On req_valid (handshake) latch write/addr/size/unsigned/wdata, load
//       counter with WAIT_STATES, go WAIT. req_ready=0 in all other states.
//     WAIT: counter decrements each cycle; when counter==0 perform the access this cycle
//       (store commits, load data and error registered) and go RESP. With WAIT_STATES=0,
//       WAIT lasts exactly one cycle.
//     RESP: rsp_valid=1, rsp_rdata/rsp_error stable until rsp_valid&&rsp_ready; then IDLE,
//       rsp_valid=0 next cycle. No new request accepted in the same cycle as response handshake.
//   Latency: request handshake at edge N -> rsp_valid high from edge N+WAIT_STATES+1.
//   Word index = addr[31:2]; lane = addr[1:0].
//   Error (checked on latched request, priority irrelevant, any one sets rsp_error=1):
//     size==11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
//     On error: no array write, rsp_rdata=0.
//   Loads: byte = word[8*lane+:8], half = word[16*addr[1]+:16]; extend per req_unsigned.
//   Stores: only addressed byte lanes modified (byte: 1 lane, half: 2, word: 4);
//     other lanes of the word keep prior contents. rsp_rdata=0, rsp_error=0 on success.
//   Reset asserted in any state: immediate return to IDLE, outputs to reset values; a store
//     whose commit cycle has not yet occurred never reaches the array.
//   Request inputs are ignored outside IDLE; changing them mid-transaction has no effect.
// TESTING
//   sw 0xDEADBEEF @0x10, then lw @0x10, WAIT_STATES=2 -> rsp_valid 3 cycles after each req
//     handshake; load returns 0xDEADBEEF, rsp_error=0.
//   After above, sb 0x55 @0x12, lw @0x10 -> 0xDE55BEEF; lbu @0x13 -> 0x000000DE;
//     lb @0x13 -> 0xFFFFFFDE; lh @0x12 -> 0xFFFFDE55.
//   lw @0x11, sh @0x13, size=11, lw @4*DEPTH_WORDS -> each rsp_error=1, rsp_rdata=0;
//     following lw @0x10 unchanged.
//   rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0,
//     new req_valid not accepted until after response handshake.
//   Assert reset during WAIT of sw 0x12345678 @0x20 (prior content 0) -> outputs reset at once,
//     req_ready=1; subsequent lw @0x20 returns 0.
//   WAIT_STATES=0 build: back-to-back requests -> one response every 3 cycles with rsp_ready=1.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, a fixed number of wait states,
// then a held response carrying extended load data or a store acknowledge.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_WAIT    = 2'd1;
    localparam logic [1:0]  S_RESP    = 2'd2;
    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             commit;
    logic             error_c;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_rd;
    logic [31:0]      wlanes;
    logic [3:0]       be;

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
        return uns ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
        return uns ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] load_data(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
        case (size)
            2'b00:   return extend_byte(word[{lane, 3'b000} +: 8], uns);
            2'b01:   return extend_half(word[{lane[1], 4'b0000} +: 16], uns);
            default: return word;
        endcase
    endfunction

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign commit    = (state == S_WAIT) && (cnt == 4'd0);
    assign idx       = addr_q[IDX_W+1:2];
    assign word_rd   = mem[idx];

    always_comb begin
        error_c = (size_q == 2'b11)
                | ((size_q == 2'b01) & addr_q[0])
                | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
                | (addr_q[31:2] >= DEPTH_LIM);
    end

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        wlanes = '0;
        be     = '0;
        case (size_q)
            2'b00: begin
                wlanes = {4{wdata_q[7:0]}};
                be     = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                wlanes = {2{wdata_q[15:0]}};
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wlanes = wdata_q;
                be     = 4'b1111;
            end
            default: begin
                wlanes = '0;
                be     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && write_q && !error_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state <= S_WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        rsp_error <= error_c;
                        rsp_rdata <= (write_q || error_c) ? 32'd0
                                   : load_data(word_rd, addr_q[1:0], size_q, unsigned_q);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
